// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
// Two-requester arbiter sharing one 8-bit ALU through an IDLE/EXEC/RESP handshake FSM.
// alu8 is the shared datapath: opcode selects add/sub/logic/shift/invert with carry in/out.

module alu8 (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [2:0] Op,
    input  logic       Cin,
    output logic [7:0] Y,
    output logic       Cout
);
    logic [8:0] sum;
    logic [8:0] diff;

    always_comb begin
        sum  = {1'b0, A} + {1'b0, B} + {8'd0, Cin};
        // 9-bit wrap leaves the borrow in bit 8 when A - B - Cin goes negative
        diff = {1'b0, A} - {1'b0, B} - {8'd0, Cin};
        Y    = 8'd0;
        Cout = 1'b0;
        case (Op)
            3'b000: {Cout, Y} = sum;
            3'b001: {Cout, Y} = diff;
            3'b010: Y = A & B;
            3'b011: Y = A | B;
            3'b100: Y = A ^ B;
            3'b101: {Cout, Y} = {A, Cin};
            3'b110: {Y, Cout} = {Cin, A};
            default: Y = ~A;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int RR = 1
) (
    input  logic        CLK_100MHZ,
    input  logic        RST,
    input  logic        REQ0_VALID,
    output logic        REQ0_READY,
    input  logic [7:0]  REQ0_A,
    input  logic [7:0]  REQ0_B,
    input  logic [2:0]  REQ0_OP,
    input  logic        REQ0_CIN,
    input  logic        REQ1_VALID,
    output logic        REQ1_READY,
    input  logic [7:0]  REQ1_A,
    input  logic [7:0]  REQ1_B,
    input  logic [2:0]  REQ1_OP,
    input  logic        REQ1_CIN,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic        RSP_ID,
    output logic [7:0]  RSP_Y,
    output logic        RSP_COUT,
    output logic        BUSY,
    output logic [15:0] OP_COUNT
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic        cin_q, cin_d;
    logic        id_q, id_d;
    logic [7:0]  y_q, y_d;
    logic        cout_q, cout_d;
    logic [15:0] op_count_q, op_count_d;
    logic        grant1;
    logic [7:0]  alu_y;
    logic        alu_cout;

    alu8 u_alu (
        .A    (a_q),
        .B    (b_q),
        .Op   (op_q),
        .Cin  (cin_q),
        .Y    (alu_y),
        .Cout (alu_cout)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        cin_d      = cin_q;
        id_d       = id_q;
        y_d        = y_q;
        cout_d     = cout_q;
        op_count_d = op_count_q;
        REQ0_READY = 1'b0;
        REQ1_READY = 1'b0;
        // Contention under round-robin alternates; otherwise requester 0 wins when present
        grant1 = (RR != 0 && REQ0_VALID && REQ1_VALID) ? ~last_q : ~REQ0_VALID;
        case (state_q)
            IDLE: begin
                if (!RST && (REQ0_VALID || REQ1_VALID)) begin
                    REQ0_READY = ~grant1;
                    REQ1_READY = grant1;
                    a_d        = grant1 ? REQ1_A   : REQ0_A;
                    b_d        = grant1 ? REQ1_B   : REQ0_B;
                    op_d       = grant1 ? REQ1_OP  : REQ0_OP;
                    cin_d      = grant1 ? REQ1_CIN : REQ0_CIN;
                    id_d       = grant1;
                    last_d     = grant1;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                y_d     = alu_y;
                cout_d  = alu_cout;
                state_d = RESP;
            end
            RESP: begin
                if (RSP_READY) begin
                    state_d    = IDLE;
                    op_count_d = op_count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_100MHZ or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            a_q        <= 8'd0;
            b_q        <= 8'd0;
            op_q       <= 3'd0;
            cin_q      <= 1'b0;
            id_q       <= 1'b0;
            y_q        <= 8'd0;
            cout_q     <= 1'b0;
            op_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            cin_q      <= cin_d;
            id_q       <= id_d;
            y_q        <= y_d;
            cout_q     <= cout_d;
            op_count_q <= op_count_d;
        end
    end

    assign RSP_VALID = (state_q == RESP);
    assign BUSY      = (state_q != IDLE);
    assign RSP_ID    = id_q;
    assign RSP_Y     = y_q;
    assign RSP_COUT  = cout_q;
    assign OP_COUNT  = op_count_q;
endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
// Bench for alu_arbiter: a round-robin and a fixed-priority instance share stimulus and are
// each compared every cycle against a transaction-level model, plus directed checks.
module tb_alu_arbiter;
    logic        clk, rst;
    logic        v0, v1, rsp_ready;
    logic [7:0]  a0, b0, a1, b1;
    logic [2:0]  op0, op1;
    logic        cin0, cin1;

    logic        o_r0 [2];
    logic        o_r1 [2];
    logic        o_vld [2];
    logic        o_id [2];
    logic [7:0]  o_y [2];
    logic        o_c [2];
    logic        o_busy [2];
    logic [15:0] o_cnt [2];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    string nm [2] = '{"rr", "fp"};

    // model state per instance (index 0 = round-robin, 1 = fixed priority)
    bit        pending [2];
    int        resp_at [2];
    bit        last [2];
    bit [15:0] cnt [2];
    int        ey [2];
    int        ec [2];
    int        eid [2];

    alu_arbiter #(.RR(1)) u_rr (
        .CLK_100MHZ(clk), .RST(rst),
        .REQ0_VALID(v0), .REQ0_READY(o_r0[0]), .REQ0_A(a0), .REQ0_B(b0), .REQ0_OP(op0), .REQ0_CIN(cin0),
        .REQ1_VALID(v1), .REQ1_READY(o_r1[0]), .REQ1_A(a1), .REQ1_B(b1), .REQ1_OP(op1), .REQ1_CIN(cin1),
        .RSP_VALID(o_vld[0]), .RSP_READY(rsp_ready), .RSP_ID(o_id[0]), .RSP_Y(o_y[0]),
        .RSP_COUT(o_c[0]), .BUSY(o_busy[0]), .OP_COUNT(o_cnt[0])
    );

    alu_arbiter #(.RR(0)) u_fp (
        .CLK_100MHZ(clk), .RST(rst),
        .REQ0_VALID(v0), .REQ0_READY(o_r0[1]), .REQ0_A(a0), .REQ0_B(b0), .REQ0_OP(op0), .REQ0_CIN(cin0),
        .REQ1_VALID(v1), .REQ1_READY(o_r1[1]), .REQ1_A(a1), .REQ1_B(b1), .REQ1_OP(op1), .REQ1_CIN(cin1),
        .RSP_VALID(o_vld[1]), .RSP_READY(rsp_ready), .RSP_ID(o_id[1]), .RSP_Y(o_y[1]),
        .RSP_COUT(o_c[1]), .BUSY(o_busy[1]), .OP_COUNT(o_cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void alu_ref(input int op, input int a, input int b, input int cin,
                                    output int y, output int c);
        int s;
        c = 0;
        case (op)
            0: begin s = a + b + cin; y = s % 256; c = s / 256; end
            1: begin s = a - b - cin; c = (s < 0) ? 1 : 0; y = (s + 256) % 256; end
            2: y = a & b;
            3: y = a | b;
            4: y = a ^ b;
            5: begin s = a * 2 + cin; y = s % 256; c = s / 256; end
            6: begin y = a / 2 + cin * 128; c = a % 2; end
            default: y = 255 - a;
        endcase
    endfunction

    // -1: nobody asks; otherwise the requester the rules select
    function automatic int grant_of(input int k);
        if (!v0 && !v1) return -1;
        if (v0 && v1) return (k == 0) ? (last[k] ? 0 : 1) : 0;
        return v0 ? 0 : 1;
    endfunction

    task automatic step();
        int g, y, c;
        bit ev;
        #1;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                pending[k] = 0; last[k] = 1; cnt[k] = 0;
                ey[k] = 0; ec[k] = 0; eid[k] = 0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            g  = grant_of(k);
            ev = pending[k] && (cyc >= resp_at[k]);
            chk({nm[k], " ready0"}, o_r0[k], !rst && !pending[k] && g == 0);
            chk({nm[k], " ready1"}, o_r1[k], !rst && !pending[k] && g == 1);
            chk({nm[k], " rsp_valid"}, o_vld[k], ev);
            chk({nm[k], " busy"}, o_busy[k], pending[k]);
            chk({nm[k], " op_count"}, o_cnt[k], cnt[k]);
            if (ev || rst) begin
                chk({nm[k], " rsp_y"}, o_y[k], ey[k]);
                chk({nm[k], " rsp_cout"}, o_c[k], ec[k]);
                chk({nm[k], " rsp_id"}, o_id[k], eid[k]);
            end
        end
        @(posedge clk);
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                g = grant_of(k);
                if (pending[k]) begin
                    if (cyc >= resp_at[k] && rsp_ready) begin
                        cnt[k]++;
                        pending[k] = 0;
                    end
                end else if (g >= 0) begin
                    if (g == 0) alu_ref(op0, a0, b0, cin0, y, c);
                    else        alu_ref(op1, a1, b1, cin1, y, c);
                    ey[k] = y; ec[k] = c; eid[k] = g;
                    pending[k] = 1;
                    resp_at[k] = cyc + 2;
                    last[k] = (g == 1);
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    // Single-requester operation: both instances behave identically, so check both.
    task automatic send(input int n, input int a, input int b, input int op, input int cin,
                        input int ey_c, input int ec_c);
        if (n == 0) begin v0 = 1; a0 = a[7:0]; b0 = b[7:0]; op0 = op[2:0]; cin0 = cin[0]; end
        else        begin v1 = 1; a1 = a[7:0]; b1 = b[7:0]; op1 = op[2:0]; cin1 = cin[0]; end
        step();
        v0 = 0; v1 = 0;
        step();
        for (int k = 0; k < 2; k++) begin
            chk({nm[k], " lat rsp_valid"}, o_vld[k], 1);
            chk({nm[k], " dir rsp_y"}, o_y[k], ey_c);
            chk({nm[k], " dir rsp_cout"}, o_c[k], ec_c);
            chk({nm[k], " dir rsp_id"}, o_id[k], n);
        end
        step();
    endtask

    initial begin
        logic        id_q_rr [$];
        logic        id_q_fp [$];
        logic [7:0]  y_q_rr [$];
        logic [7:0]  y_q_fp [$];
        logic [7:0]  held_y;
        logic [15:0] held_cnt;
        int          exp_id_rr [4] = '{0, 1, 0, 1};
        int          exp_y_rr [4]  = '{15, 16, 15, 16};

        rst = 0; v0 = 0; v1 = 0; rsp_ready = 1;
        a0 = 0; b0 = 0; op0 = 0; cin0 = 0; a1 = 0; b1 = 0; op1 = 0; cin1 = 0;
        #2 rst = 1;
        @(negedge clk);

        // reset held with both requesters asking: no READY may appear
        v0 = 1; v1 = 1;
        repeat (3) step();
        v0 = 0; v1 = 0; rst = 0;
        repeat (2) step();

        // basic add, carry-out wrap
        send(0, 3, 5, 0, 0, 8, 0);
        chk("rr op_count after first", o_cnt[0], 1);
        send(1, 255, 1, 0, 0, 0, 1);

        // contention: both VALID held for four operations
        v0 = 1; a0 = 7;  b0 = 8; op0 = 0; cin0 = 0;
        v1 = 1; a1 = 15; b1 = 1; op1 = 0; cin1 = 0;
        for (int i = 0; i < 12; i++) begin
            if (o_vld[0]) begin id_q_rr.push_back(o_id[0]); y_q_rr.push_back(o_y[0]); end
            if (o_vld[1]) begin id_q_fp.push_back(o_id[1]); y_q_fp.push_back(o_y[1]); end
            step();
        end
        v0 = 0; v1 = 0;
        chk("rr contention count", id_q_rr.size(), 4);
        chk("fp contention count", id_q_fp.size(), 4);
        for (int i = 0; i < 4 && i < id_q_rr.size() && i < id_q_fp.size(); i++) begin
            chk($sformatf("rr seq id %0d", i), id_q_rr[i], exp_id_rr[i]);
            chk($sformatf("rr seq y %0d", i), y_q_rr[i], exp_y_rr[i]);
            chk($sformatf("fp seq id %0d", i), id_q_fp[i], 0);
            chk($sformatf("fp seq y %0d", i), y_q_fp[i], 15);
        end

        // consumer stalls five cycles in RESP while requesters keep asking
        rsp_ready = 0;
        v0 = 1; a0 = 10; b0 = 3; op0 = 1; cin0 = 0;
        step();
        v0 = 1; v1 = 1;
        step();
        held_y = o_y[0];
        held_cnt = o_cnt[0];
        chk("stall first y", held_y, 7);
        repeat (5) begin
            chk("stall rsp_valid", o_vld[0], 1);
            chk("stall rsp_y", o_y[0], held_y);
            chk("stall ready0", o_r0[0], 0);
            chk("stall ready1", o_r1[0], 0);
            chk("stall busy", o_busy[0], 1);
            chk("stall op_count", o_cnt[0], held_cnt);
            step();
        end
        v0 = 0; v1 = 0; rsp_ready = 1;
        step();
        chk("stall op_count after", o_cnt[0], held_cnt + 16'd1);

        // reset pulse while an operation is in EXEC
        v0 = 1; a0 = 3; b0 = 5; op0 = 0; cin0 = 0;
        step();
        v0 = 0; rst = 1;
        step();
        chk("rst busy", o_busy[0], 0);
        chk("rst op_count", o_cnt[0], 0);
        chk("rst rsp_y", o_y[0], 0);
        rst = 0;
        repeat (4) begin
            chk("post-rst no rsp_valid", o_vld[0], 0);
            step();
        end
        send(0, 3, 5, 0, 0, 8, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
            a0 = 8'($urandom_range(0, 255)); b0 = 8'($urandom_range(0, 255));
            a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
            op0 = 3'($urandom_range(0, 7)); op1 = 3'($urandom_range(0, 7));
            cin0 = 1'($urandom_range(0, 1)); cin1 = 1'($urandom_range(0, 1));
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        v0 = 0; v1 = 0; rsp_ready = 1;
        repeat (4) step();

        // counter wrap: preload near the top, then complete two operations
        force u_rr.op_count_q = 16'hFFFE;
        force u_fp.op_count_q = 16'hFFFE;
        #1;
        release u_rr.op_count_q;
        release u_fp.op_count_q;
        cnt[0] = 16'hFFFE; cnt[1] = 16'hFFFE;
        send(0, 1, 2, 0, 1, 4, 0);
        send(1, 200, 100, 1, 0, 100, 0);
        chk("rr op_count wrap", o_cnt[0], 16'h0000);
        chk("fp op_count wrap", o_cnt[1], 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter RR, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority (requester 0 wins).
REQ-002 SHALL have port CLK_100MHZ  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports REQ0_VALID / REQ1_VALID  input  1 each  requester n presents an operation.
REQ-005 SHALL have ports REQ0_READY / REQ1_READY  output  1 each  arbiter accepts requester n this cycle.
REQ-006 SHALL have ports REQn_A, REQn_B  input  8 each  operands of requester n.
REQ-007 SHALL have ports REQn_OP  input  3, REQn_CIN  input  1  ALU opcode and carry-in of requester n.
REQ-008 SHALL have port RSP_VALID  output  1  result available.
REQ-009 SHALL have port RSP_READY  input  1  consumer takes result.
REQ-010 SHALL have ports RSP_ID  output  1, RSP_Y  output  8, RSP_COUT  output  1  owner, result, carry-out.
REQ-011 SHALL have port BUSY  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port OP_COUNT  output  16  number of completed response handshakes.

Function
REQ-013 SHALL instantiate one alu8 (ports A, B, Op, Cin, Y, Cout) as the single shared datapath.
REQ-014 SHALL implement states IDLE, EXEC, RESP; IDLE->EXEC on request handshake, EXEC->RESP unconditionally after one cycle, RESP->IDLE on RSP_VALID && RSP_READY.
REQ-015 SHALL assert REQn_READY only in IDLE and only for the granted requester; at most one READY high per cycle; no READY when neither VALID is high.
REQ-016 SHALL, on REQn_VALID && REQn_READY, register A, B, OP, CIN and ID=n; the alu8 is driven only from these registers.
REQ-017 SHALL, in EXEC, capture alu8 Y and Cout into result registers; RSP_Y/RSP_COUT/RSP_ID come from registers only.
REQ-018 SHALL assert RSP_VALID only in RESP and hold RSP_Y, RSP_COUT, RSP_ID stable until the response handshake.
REQ-019 SHALL give latency: handshake in cycle N -> RSP_VALID high in cycle N+2; maximum throughput one operation per 3 cycles.
REQ-020 SHALL, with RR=1 and both VALID high in IDLE, grant the requester not granted last; single VALID always granted; last-grant pointer updates at request handshake.
REQ-021 SHALL, with RR=0, grant requester 0 whenever REQ0_VALID is high.
REQ-022 SHALL ignore REQn_VALID outside IDLE; a VALID withdrawn before handshake has no effect.
REQ-023 SHALL not accept a new request in the cycle of the response handshake; next acceptance earliest in the following (IDLE) cycle.
REQ-024 SHALL pass REQn_OP to alu8 unmodified; result for any opcode is whatever alu8 produces.
REQ-025 SHALL increment OP_COUNT by 1 on each response handshake, wrapping 0xFFFF -> 0x0000.

Reset
REQ-026 SHALL, while RST high, force state IDLE, REQn_READY=0, RSP_VALID=0, BUSY=0, RSP_Y=0, RSP_COUT=0, RSP_ID=0, OP_COUNT=0, operand registers 0, last-grant pointer = 1 (requester 0 wins first contention).
REQ-027 SHALL, on reset during EXEC or RESP, discard the in-flight operation with no response after reset release.

Verification
REQ-028 SHALL check: REQ0 A=3, B=5, OP=000, CIN=0, RSP_READY=1 -> RSP_VALID two cycles after handshake, RSP_Y=8, RSP_COUT=0, RSP_ID=0, OP_COUNT=1.
REQ-029 SHALL check: REQ1 A=255, B=1, OP=000, CIN=0 -> RSP_Y=0, RSP_COUT=1, RSP_ID=1.
REQ-030 SHALL check: RR=1, both VALID held high for 4 operations (REQ0 7+8, REQ1 15+1) -> RSP_ID sequence 0,1,0,1, RSP_Y 15,16,15,16; RR=0 same stimulus -> 0,0,0,0.
REQ-031 SHALL check: RSP_READY low 5 cycles in RESP -> RSP_VALID and data stable, both READY low, BUSY=1, OP_COUNT unchanged until handshake.
REQ-032 SHALL check: RST pulsed in EXEC -> all outputs at reset values, no RSP_VALID afterwards until a new request; then 3+5 -> RSP_Y=8.
REQ-033 SHALL check: 65536 completed operations -> OP_COUNT returns to 0x0000.
